// File: rtl/sram_1rw1r_param_sky130.sv
// sram_1rw1r_param_sky130
//   Behavioural single-clock SRAM with one read/write port (port 0) and one
//   read-only port (port 1). Supports per-lane write masking, 1- or 2-cycle
//   read latency, a selectable read-during-write policy on port 1, and an
//   optional zero-clear sweep after reset.
//
// Ports
//   clk0        clock for both ports, all state on the rising edge
//   rst0        synchronous active-high reset
//   csb0/web0   port 0 active-low chip select / active-low write enable
//   wmask0      port 0 per-lane write enable (lane i = bits [i*WRITE_SIZE +: WRITE_SIZE])
//   addr0/din0  port 0 address / write data
//   dout0       port 0 read data, holds until the next port 0 read completes
//   rvalid0     one-cycle pulse when dout0 carries new read data
//   csb1/addr1  port 1 active-low chip select / address
//   dout1       port 1 read data, holds until the next port 1 read completes
//   rvalid1     one-cycle pulse when dout1 carries new read data
//   collision1  pulses with rvalid1 when that read met a same-edge port 0
//               write to the same address
//   busy        high while the clear sweep runs (and during reset when the
//               sweep is enabled)
//
// Handshake: a request is taken at a rising edge when its csb is low, rst0 is
// low and the clear sweep is not running; there is no back-pressure, so a
// taken read always produces exactly one rvalid pulse READ_LATENCY edges
// later (counting the request edge as the first) unless rst0 intervenes.
module sram_1rw1r_param_sky130 #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int WRITE_SIZE     = 8,
    parameter int NUM_WMASKS     = DATA_WIDTH / WRITE_SIZE,
    parameter int READ_LATENCY   = 1,
    parameter int COLLISION_MODE = 0,
    parameter int CLEAR_ON_RESET = 0
) (
`ifdef USE_POWER_PINS
    inout  wire                    vccd1,
    inout  wire                    vssd1,
`endif
    input  logic                   clk0,
    input  logic                   rst0,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [NUM_WMASKS-1:0]  wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    output logic                   rvalid0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   rvalid1,
    output logic                   collision1,
    output logic                   busy
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

    // Elaboration-time parameter sanity checks.
    if ((DATA_WIDTH % WRITE_SIZE) != 0) begin : g_bad_write_size
        $error("sram_1rw1r_param_sky130: WRITE_SIZE must divide DATA_WIDTH");
    end
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
        $error("sram_1rw1r_param_sky130: READ_LATENCY must be 1 or 2");
    end

    // ------------------------------------------------------------------
    // Clear sequencer (state is kept observable through clr_state_q)
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } clr_state_t;

    clr_state_t            clr_state_q;
    clr_state_t            clr_state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic                  clr_we;
    logic                  clearing;

    // State register; the sweep address lives here since it only moves
    // together with the state.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            clr_state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            clr_addr_q  <= '0;
        end else begin
            clr_state_q <= clr_state_d;
            if (clr_we) begin
                clr_addr_q <= clr_addr_q + 1'b1;
            end
        end
    end

    // Next state: leave CLEAR after the last word has been zeroed.
    always_comb begin
        clr_state_d = clr_state_q;
        if ((clr_state_q == S_CLEAR) && (&clr_addr_q)) begin
            clr_state_d = S_IDLE;
        end
    end

    // Outputs of the sequencer.
    always_comb begin
        clearing = (clr_state_q == S_CLEAR);
        clr_we   = clearing && !rst0;
        busy     = clearing || (rst0 && (CLEAR_ON_RESET != 0));
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic rd0;
    logic wr0;
    logic rd1;
    logic coll;

    always_comb begin
        rd0  = !csb0 && !rst0 && !clearing &&  web0;
        wr0  = !csb0 && !rst0 && !clearing && !web0;
        rd1  = !csb1 && !rst0 && !clearing;
        coll = rd1 && wr0 && (addr0 == addr1);
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk0) begin
        if (clr_we) begin
            mem[clr_addr_q] <= '0;
        end else if (wr0) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (wmask0[i]) begin
                    mem[addr0][i*WRITE_SIZE +: WRITE_SIZE] <= din0[i*WRITE_SIZE +: WRITE_SIZE];
                end
            end
        end
    end

    // Read words as seen at the request edge. Port 1 in write-through mode
    // takes the masked lanes of din0 when it collides with a port 0 write.
    logic [DATA_WIDTH-1:0] rd_word0;
    logic [DATA_WIDTH-1:0] rd_word1;

    always_comb begin
        rd_word0 = mem[addr0];
        rd_word1 = mem[addr1];
        if ((COLLISION_MODE == 1) && coll) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (wmask0[i]) begin
                    rd_word1[i*WRITE_SIZE +: WRITE_SIZE] = din0[i*WRITE_SIZE +: WRITE_SIZE];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: the optional extra stage is bypassed for latency 1.
    // ------------------------------------------------------------------
    logic                  p0_valid;
    logic [DATA_WIDTH-1:0] p0_data;
    logic                  p1_valid;
    logic                  p1_coll;
    logic [DATA_WIDTH-1:0] p1_data;

    logic                  s0_valid;
    logic [DATA_WIDTH-1:0] s0_data;
    logic                  s1_valid;
    logic                  s1_coll;
    logic [DATA_WIDTH-1:0] s1_data;

    always_comb begin
        if (READ_LATENCY == 1) begin
            s0_valid = rd0;
            s0_data  = rd_word0;
            s1_valid = rd1;
            s1_coll  = coll;
            s1_data  = rd_word1;
        end else begin
            s0_valid = p0_valid;
            s0_data  = p0_data;
            s1_valid = p1_valid;
            s1_coll  = p1_coll;
            s1_data  = p1_data;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            p0_valid   <= 1'b0;
            p1_valid   <= 1'b0;
            p1_coll    <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            collision1 <= 1'b0;
            dout0      <= '0;
            dout1      <= '0;
        end else begin
            p0_valid   <= rd0;
            p1_valid   <= rd1;
            p1_coll    <= coll;
            rvalid0    <= s0_valid;
            rvalid1    <= s1_valid;
            collision1 <= s1_valid && s1_coll;
            if (s0_valid) begin
                dout0 <= s0_data;
            end
            if (s1_valid) begin
                dout1 <= s1_data;
            end
        end
    end

    // Stage data needs no reset: it is only consumed when its valid is set.
    always_ff @(posedge clk0) begin
        if (rd0) begin
            p0_data <= rd_word0;
        end
        if (rd1) begin
            p1_data <= rd_word1;
        end
    end

endmodule

// File: doc/sram_1rw1r_param_sky130.md
# sram_1rw1r_param_sky130

Parametrised synchronous single-clock SRAM model with one read/write port (port 0) and one read-only port (port 1). Adds per-byte write masking at any write granularity, a selectable read latency, a defined read-during-write collision policy, and an optional zero-clear sequencer after reset. It sits beside the user-project Wishbone slaves as the behavioural RAM for simulation and FPGA builds.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 8, address width; RAM_DEPTH = 1 << ADDR_WIDTH
- WRITE_SIZE, 8, bits per write-mask lane; must divide DATA_WIDTH
- NUM_WMASKS, DATA_WIDTH/WRITE_SIZE, derived mask width
- READ_LATENCY, 1, 1 or 2 cycles
- COLLISION_MODE, 0, 0 = port 1 returns old data on same-address write; 1 = returns new (write-through) data
- CLEAR_ON_RESET, 0, 1 = zero every word after reset
- Power pins vccd1/vssd1 (inout) present only under USE_POWER_PINS
- clk0  in  1  single clock for both ports; all state on rising edge
- rst0  in  1  synchronous, active-high reset
- csb0  in  1  port 0 active-low chip select
- web0  in  1  port 0 active-low write enable
- wmask0  in  NUM_WMASKS  per-lane write enable, bit i covers bits [i*WRITE_SIZE +: WRITE_SIZE]
- addr0  in  ADDR_WIDTH  port 0 address
- din0  in  DATA_WIDTH  port 0 write data
- dout0  out  DATA_WIDTH  port 0 read data
- rvalid0  out  1  one-cycle pulse: dout0 carries new read data
- csb1  in  1  port 1 active-low chip select
- addr1  in  ADDR_WIDTH  port 1 address
- dout1  out  DATA_WIDTH  port 1 read data
- rvalid1  out  1  one-cycle pulse: dout1 carries new read data
- collision1  out  1  pulses with rvalid1 when that read hit a same-edge port 0 write to the same address
- busy  out  1  high while clear sequencer runs; requests ignored

## Operation
- Accepted request: selected port's csb low at a rising edge with rst0 low and busy low.
- Port 0 write (web0=0): lanes with wmask0[i]=1 updated at that edge; other lanes keep content; wmask0=0 is a legal no-op write. No rvalid0, dout0 holds.
- Port 0 read (web0=1): mem[addr0] returned. Port 1 read: mem[addr1] returned.
- Collision (port 0 write and port 1 read, same address, same edge): mode 0 -> dout1 = pre-write word; mode 1 -> dout1 = written lanes from din0, unmasked lanes old; collision1=1 with rvalid1. Different addresses: no flag.
- dout0/dout1 hold last read data until next read on that port.
- Clear sequencer states: IDLE, CLEAR. rst0 high -> counter=0; on rst0 release state=CLEAR if CLEAR_ON_RESET else IDLE. CLEAR writes zero to mem[counter] per cycle, counter++; after writing RAM_DEPTH-1 -> IDLE.
- rst0 asserted during CLEAR restarts from address 0.
- Memory contents unaffected by rst0 when CLEAR_ON_RESET=0 (undefined until written).
- DATA_WIDTH % WRITE_SIZE ≠ 0 or READ_LATENCY ∉ {1,2}: $error at time 0.

## Timing
- Reset values: dout0=0, dout1=0, rvalid0=0, rvalid1=0, collision1=0; busy=1 during and after rst0 when CLEAR_ON_RESET=1 (else 0); internal read pipeline flushed.
- CLEAR duration: busy high exactly RAM_DEPTH cycles after rst0 falls; first request accepted at the edge where busy is sampled low.
- Read sampled at edge k: READ_LATENCY=1 -> dout/rvalid updated at edge k (visible cycle k+1); READ_LATENCY=2 -> at edge k+1.
- Back-to-back reads every cycle supported on both ports; rvalid stays high for consecutive reads.
- Write at edge k visible to any read sampled at edge k+1.
- Reset with a read in flight: read dropped, no rvalid.

## Test plan
- Basic R/W, latency 1: write addr 0x05 din 0xDEADBEEF wmask 0xF, then port 0 read 0x05 -> dout0=0xDEADBEEF, rvalid0 one cycle after read edge; latency 2 -> one cycle later.
- Byte mask: over 0xDEADBEEF write din 0x11223344 wmask 0b0101 -> read 0xDE22BE44.
- Collision: port 0 write 0xAAAAAAAA to 0x10 (old 0x12345678, wmask 0xF) with port 1 read 0x10 same edge -> mode 0 dout1=0x12345678, mode 1 dout1=0xAAAAAAAA; collision1=1 both modes.
- Clear: CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> busy 16 cycles after rst0 falls; read addr 0xF -> 0x00000000; request during busy -> no write, no rvalid.
- Reset mid-clear at counter 7 -> counter restarts at 0, busy full 16 cycles again.
- Generality: DATA_WIDTH=64, WRITE_SIZE=16 -> wmask 0b1000 writes only bits [63:48]; streaming reads on port 1 every cycle -> rvalid1 continuously high, data in order.
